// File: rtl/j_fdsyncr_dbuf.sv
// j_fdsyncr_dbuf: byte-lane writable register with an optional shadow stage.
// MODE 0 loads lanes straight into q. MODE 1 stages lanes in a shadow register
// and moves them into q on a commit. A commit that arrives alongside lane
// loads carries those new lanes into q on the same edge.
module j_fdsyncr_dbuf #(
    parameter int                 WIDTH  = 32,
    parameter int                 LANES  = WIDTH / 8,
    parameter int                 MODE   = 1,
    parameter logic [WIDTH-1:0]   RSTVAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  d,
    input  logic [LANES-1:0]  ld,
    input  logic              commit,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  shadow,
    output logic              pending,
    output logic              committed
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             committed_q, committed_d;

    logic [WIDTH-1:0] shadow_merged;
    logic [WIDTH-1:0] q_merged;
    logic             any_ld;
    logic             commit_take;

    // Overlay the loaded lanes of d on the current shadow and on the current q.
    always_comb begin
        shadow_merged = shadow_q;
        q_merged      = q_q;
        for (int i = 0; i < LANES; i++) begin
            if (ld[i]) begin
                shadow_merged[8*i +: 8] = d[8*i +: 8];
                q_merged[8*i +: 8]      = d[8*i +: 8];
            end
        end
    end

    // A commit only counts when there is something to transfer: either staged
    // data or lanes arriving in the same cycle.
    assign any_ld      = |ld;
    assign commit_take = commit && (pending_q || any_ld);

    // Next-state selection for both modes.
    always_comb begin
        q_d         = q_q;
        shadow_d    = shadow_q;
        pending_d   = 1'b0;
        committed_d = 1'b0;
        if (MODE == 0) begin
            q_d      = q_merged;
            shadow_d = q_merged;
        end else begin
            shadow_d = shadow_merged;
            if (commit_take) begin
                q_d         = shadow_merged;
                pending_d   = 1'b0;
                committed_d = 1'b1;
            end else begin
                pending_d   = pending_q || any_ld;
            end
        end
    end

    // State registers; reset overrides any load or commit in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q         <= RSTVAL;
            shadow_q    <= RSTVAL;
            pending_q   <= 1'b0;
            committed_q <= 1'b0;
        end else begin
            q_q         <= q_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            committed_q <= committed_d;
        end
    end

    assign q         = q_q;
    assign shadow    = shadow_q;
    assign pending   = pending_q;
    assign committed = committed_q;

endmodule

// File: tb/tb_j_fdsyncr_dbuf.sv
// Bench for j_fdsyncr_dbuf: a directed vector table and random traffic against
// a lane-level model on a MODE 1 / 32-bit instance, plus a hand-written
// sequence on a MODE 0 / 16-bit instance.
module tb_j_fdsyncr_dbuf;

    logic clk;

    // MODE 1, WIDTH 32 instance
    logic        rst1;
    logic [31:0] d1;
    logic [3:0]  ld1;
    logic        commit1;
    logic [31:0] q1, shadow1;
    logic        pending1, committed1;

    // MODE 0, WIDTH 16 instance
    logic        rst0;
    logic [15:0] d0;
    logic [1:0]  ld0;
    logic        commit0;
    logic [15:0] q0, shadow0;
    logic        pending0, committed0;

    int checks;
    int failures;

    j_fdsyncr_dbuf #(.WIDTH(32), .MODE(1), .RSTVAL(32'h0)) dut1 (
        .clk(clk), .rst(rst1), .d(d1), .ld(ld1), .commit(commit1),
        .q(q1), .shadow(shadow1), .pending(pending1), .committed(committed1)
    );

    j_fdsyncr_dbuf #(.WIDTH(16), .MODE(0), .RSTVAL(16'h0)) dut0 (
        .clk(clk), .rst(rst0), .d(d0), .ld(ld0), .commit(commit0),
        .q(q0), .shadow(shadow0), .pending(pending0), .committed(committed0)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  ld;
        logic [31:0] d;
        logic        commit;
        logic [31:0] exp_q;
        logic [31:0] exp_sh;
        logic        exp_pend;
        logic        exp_comm;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl[NVEC];

    function automatic vec_t mk(logic r, logic [3:0] l, logic [31:0] dd, logic c,
                                logic [31:0] eq, logic [31:0] es, logic ep, logic ec);
        vec_t v;
        v.rst = r; v.ld = l; v.d = dd; v.commit = c;
        v.exp_q = eq; v.exp_sh = es; v.exp_pend = ep; v.exp_comm = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // one clock cycle on the MODE 1 instance: drive, clock, sample after edge
    task automatic step1(input logic r, input logic [3:0] l, input logic [31:0] dd, input logic c);
        rst1 = r; ld1 = l; d1 = dd; commit1 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step0(input logic r, input logic [1:0] l, input logic [15:0] dd, input logic c);
        rst0 = r; ld0 = l; d0 = dd; commit0 = c;
        @(posedge clk);
        #1;
    endtask

    // Reference model: state held as arrays of bytes, updated from the rules
    // "loads land in the shadow; a commit with something to move copies the
    // shadow (including same-cycle loads) into q and pulses committed".
    byte unsigned m_q[4];
    byte unsigned m_sh[4];
    bit           m_pend;
    bit           m_comm;

    task automatic model_step(input logic r, input logic [3:0] l, input logic [31:0] dd, input logic c);
        bit has_data;
        if (r) begin
            foreach (m_q[i]) begin m_q[i] = 8'h00; m_sh[i] = 8'h00; end
            m_pend = 0;
            m_comm = 0;
            return;
        end
        for (int i = 0; i < 4; i++)
            if (l[i]) m_sh[i] = dd[8*i +: 8];
        has_data = m_pend || (l != 4'b0000);
        if (c && has_data) begin
            m_q    = m_sh;
            m_pend = 0;
            m_comm = 1;
        end else begin
            m_pend = has_data;
            m_comm = 0;
        end
    endtask

    function automatic logic [31:0] pack(input byte unsigned b[4]);
        return {b[3], b[2], b[1], b[0]};
    endfunction

    initial begin
        logic r;
        logic [3:0] l;
        logic [31:0] dd;
        logic c;

        checks = 0;
        failures = 0;
        rst1 = 1; ld1 = 0; d1 = 0; commit1 = 0;
        rst0 = 1; ld0 = 0; d0 = 0; commit0 = 0;
        @(posedge clk);
        #1;

        // directed vector table (MODE 1, RSTVAL 0)
        //             rst ld     d             cm  q             shadow        p  c
        tbl[0]  = mk(1, 4'h0, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 0, 0);
        tbl[1]  = mk(0, 4'hF, 32'h1234_5678, 0, 32'h0000_0000, 32'h1234_5678, 1, 0);
        tbl[2]  = mk(0, 4'h0, 32'h0000_0000, 1, 32'h1234_5678, 32'h1234_5678, 0, 1);
        tbl[3]  = mk(0, 4'h0, 32'h0000_0000, 0, 32'h1234_5678, 32'h1234_5678, 0, 0);
        tbl[4]  = mk(1, 4'h0, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 0, 0);
        tbl[5]  = mk(0, 4'hF, 32'h1234_5678, 0, 32'h0000_0000, 32'h1234_5678, 1, 0);
        tbl[6]  = mk(0, 4'h1, 32'h0000_00AA, 1, 32'h1234_56AA, 32'h1234_56AA, 0, 1);
        tbl[7]  = mk(0, 4'h0, 32'h0000_0000, 1, 32'h1234_56AA, 32'h1234_56AA, 0, 0);
        tbl[8]  = mk(0, 4'h0, 32'h0000_0000, 1, 32'h1234_56AA, 32'h1234_56AA, 0, 0);
        tbl[9]  = mk(0, 4'h0, 32'h0000_0000, 1, 32'h1234_56AA, 32'h1234_56AA, 0, 0);
        tbl[10] = mk(0, 4'hF, 32'hDEAD_BEEF, 0, 32'h1234_56AA, 32'hDEAD_BEEF, 1, 0);
        tbl[11] = mk(1, 4'hF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h0000_0000, 0, 0);
        tbl[12] = mk(0, 4'h0, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 0, 0);
        tbl[13] = mk(0, 4'hF, 32'hA5A5_A5A5, 1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 1);
        tbl[14] = mk(0, 4'h1, 32'h0000_0011, 0, 32'hA5A5_A5A5, 32'hA5A5_A511, 1, 0);
        tbl[15] = mk(0, 4'h4, 32'h0033_0000, 0, 32'hA5A5_A5A5, 32'hA533_A511, 1, 0);
        tbl[16] = mk(0, 4'h0, 32'h0000_0000, 1, 32'hA533_A511, 32'hA533_A511, 0, 1);
        tbl[17] = mk(0, 4'h0, 32'h0000_0000, 0, 32'hA533_A511, 32'hA533_A511, 0, 0);
        tbl[18] = mk(0, 4'h2, 32'h0000_BB00, 1, 32'hA533_BB11, 32'hA533_BB11, 0, 1);
        tbl[19] = mk(0, 4'h8, 32'hCC00_0000, 1, 32'hCC33_BB11, 32'hCC33_BB11, 0, 1);
        tbl[20] = mk(0, 4'h0, 32'h0000_0000, 1, 32'hCC33_BB11, 32'hCC33_BB11, 0, 0);
        tbl[21] = mk(0, 4'h0, 32'h0000_0000, 0, 32'hCC33_BB11, 32'hCC33_BB11, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            step1(tbl[i].rst, tbl[i].ld, tbl[i].d, tbl[i].commit);
            check($sformatf("vec%0d_q", i), q1, tbl[i].exp_q);
            check($sformatf("vec%0d_shadow", i), shadow1, tbl[i].exp_sh);
            check($sformatf("vec%0d_pending", i), {31'b0, pending1}, {31'b0, tbl[i].exp_pend});
            check($sformatf("vec%0d_committed", i), {31'b0, committed1}, {31'b0, tbl[i].exp_comm});
        end

        // randomized traffic against the model; first cycle resets both
        for (int i = 0; i < 400; i++) begin
            r  = (i == 0) || ($urandom_range(0, 29) == 0);
            l  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            dd = $urandom;
            c  = ($urandom_range(0, 2) == 0);
            model_step(r, l, dd, c);
            step1(r, l, dd, c);
            check("rnd_q", q1, pack(m_q));
            check("rnd_shadow", shadow1, pack(m_sh));
            check("rnd_pending", {31'b0, pending1}, {31'b0, m_pend});
            check("rnd_committed", {31'b0, committed1}, {31'b0, m_comm});
        end

        // MODE 0 / WIDTH 16 hand sequence
        step0(1, 2'b00, 16'h0000, 0);
        check("m0_rst_q", {16'b0, q0}, 32'h0000);
        check("m0_rst_shadow", {16'b0, shadow0}, 32'h0000);
        step0(0, 2'b10, 16'hAB00, 1);
        check("m0_ld_q", {16'b0, q0}, 32'hAB00);
        check("m0_ld_shadow", {16'b0, shadow0}, 32'hAB00);
        check("m0_ld_pending", {31'b0, pending0}, 32'h0);
        check("m0_ld_committed", {31'b0, committed0}, 32'h0);
        step0(0, 2'b00, 16'hFFFF, 0);
        check("m0_hold_q", {16'b0, q0}, 32'hAB00);
        check("m0_hold_committed", {31'b0, committed0}, 32'h0);
        step0(0, 2'b01, 16'h77CD, 1);
        check("m0_lane0_q", {16'b0, q0}, 32'hABCD);
        check("m0_lane0_shadow", {16'b0, shadow0}, 32'hABCD);
        check("m0_lane0_pending", {31'b0, pending0}, 32'h0);
        check("m0_lane0_committed", {31'b0, committed0}, 32'h0);
        step0(1, 2'b11, 16'h1234, 1);
        check("m0_rst2_q", {16'b0, q0}, 32'h0000);
        check("m0_rst2_shadow", {16'b0, shadow0}, 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
